bcd_scan_mux: RTL and testbench



---
 rtl/display_pkg.sv | 10 +
 rtl/scan_prescaler.sv | 23 ++
 rtl/bcd_scan_mux.sv | 102 ++++++++++
 tb/tb_bcd_scan_mux.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants for the 7-segment display blocks: code width, blank code
// and default scan timing for a 50 MHz clock at 1 kHz per digit.
package display_pkg;
    localparam int          DIGIT_W          = 4;
    localparam logic [3:0]  BLANK_CODE       = 4'hF;
    localparam int          CLK_HZ           = 50_000_000;
    localparam int          DIGIT_HZ         = 1_000;
    localparam int          SCAN_DIV_DEFAULT = CLK_HZ / DIGIT_HZ;
    localparam int          CNT_W_DEFAULT    = 16;
endpackage

// File: rtl/scan_prescaler.sv
// Free-running divide-by-SCAN_DIV prescaler; tick marks the last count of each
// period and the count holds while en is low.
module scan_prescaler #(
    parameter int SCAN_DIV = 50000,
    parameter int CNT_W    = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);
    logic [CNT_W-1:0] cnt;

    assign tick = en && (cnt == CNT_W'(SCAN_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/bcd_scan_mux.sv
// Multiplexed common-anode display scanner: snapshots one frame of BCD digits,
// walks them MS-first one slot per prescaler tick, with leading-zero blanking.
module bcd_scan_mux
    import display_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic [4*NUM_DIGITS-1:0]       digits_in,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    input  logic                          blank_lz,
    output logic [3:0]                    bcd_out,
    output logic [NUM_DIGITS-1:0]         digit_sel,
    output logic                          dp_out,
    output logic                          frame_start
);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    logic                          tick;
    logic [IDX_W-1:0]              idx;
    logic                          restart;
    logic [4*NUM_DIGITS-1:0]       snap;
    logic [NUM_DIGITS-1:0]         snap_dp;

    logic                          frame_wrap;
    logic [IDX_W-1:0]              nxt_idx;
    logic [4*NUM_DIGITS-1:0]       src_digits;
    logic [NUM_DIGITS-1:0]         src_dp;
    logic [NUM_DIGITS-1:0]         lz_mask;
    logic                          all_zero;
    logic [DIGIT_W-1:0]            nxt_code;
    logic                          nxt_dp;
    logic                          nxt_blank;

    scan_prescaler #(.SCAN_DIV(SCAN_DIV), .CNT_W(CNT_W)) u_presc (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .tick  (tick)
    );

    // A wrapping tick shows the freshly captured frame, so decode from the
    // live inputs on that edge rather than the stale snapshot.
    always_comb begin
        frame_wrap = restart || (idx == '0);
        nxt_idx    = frame_wrap ? IDX_W'(NUM_DIGITS - 1) : IDX_W'(idx - 1'b1);
        src_digits = frame_wrap ? digits_in : snap;
        src_dp     = frame_wrap ? dp_in : snap_dp;
        all_zero   = 1'b1;
        lz_mask    = '0;
        nxt_code   = BLANK_CODE;
        nxt_dp     = 1'b0;
        nxt_blank  = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            all_zero   = all_zero && (src_digits[k*DIGIT_W +: DIGIT_W] == '0);
            lz_mask[k] = all_zero && (k != 0);
        end
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (nxt_idx == IDX_W'(k)) begin
                nxt_code  = src_digits[k*DIGIT_W +: DIGIT_W];
                nxt_dp    = src_dp[k];
                nxt_blank = blank_lz && lz_mask[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx         <= IDX_W'(NUM_DIGITS - 1);
            restart     <= 1'b1;
            snap        <= '0;
            snap_dp     <= '0;
            bcd_out     <= BLANK_CODE;
            digit_sel   <= '1;
            dp_out      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (!en) begin
                restart   <= 1'b1;
                bcd_out   <= BLANK_CODE;
                digit_sel <= '1;
                dp_out    <= 1'b0;
            end else if (tick) begin
                idx       <= nxt_idx;
                restart   <= 1'b0;
                digit_sel <= ~(NUM_DIGITS'(1) << nxt_idx);
                bcd_out   <= nxt_blank ? BLANK_CODE : nxt_code;
                dp_out    <= nxt_dp;
                if (frame_wrap) begin
                    snap        <= digits_in;
                    snap_dp     <= dp_in;
                    frame_start <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_bcd_scan_mux.sv
// Directed bench for bcd_scan_mux with 4 digits and a 4-clock slot.
module tb_bcd_scan_mux;
    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [3:0]  bcd_out;
    logic [3:0]  digit_sel;
    logic        dp_out;
    logic        frame_start;

    int n_tests = 0;
    int n_fail  = 0;

    bcd_scan_mux #(.NUM_DIGITS(4), .SCAN_DIV(4), .CNT_W(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .digits_in   (digits_in),
        .dp_in       (dp_in),
        .blank_lz    (blank_lz),
        .bcd_out     (bcd_out),
        .digit_sel   (digit_sel),
        .dp_out      (dp_out),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] digits;
        logic [3:0]  dp;
        logic        blz;
        logic [15:0] exp_bcd;  // slot 0 (MS digit) in the top nibble
        logic [3:0]  exp_dp;   // slot 0 in bit 3
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_frame(input string name);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(1);
            if (frame_start) found = 1'b1;
        end
        if (!found) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: frame_start timeout got 0 expected 1", name);
        end
    endtask

    vec_t vecs [8];

    initial begin
        vecs[0] = '{16'h1234, 4'b0000, 1'b0, 16'h1234, 4'b0000};
        vecs[1] = '{16'h0070, 4'b0000, 1'b1, 16'hFF70, 4'b0000};
        vecs[2] = '{16'h0000, 4'b0000, 1'b1, 16'hFFF0, 4'b0000};
        vecs[3] = '{16'h0070, 4'b0000, 1'b0, 16'h0070, 4'b0000};
        vecs[4] = '{16'h0012, 4'b0010, 1'b1, 16'hFF12, 4'b0010};
        vecs[5] = '{16'hAB05, 4'b0000, 1'b1, 16'hAB05, 4'b0000};
        vecs[6] = '{16'h0F03, 4'b0001, 1'b1, 16'hFF03, 4'b0001};
        vecs[7] = '{16'h0005, 4'b1100, 1'b1, 16'hFFF5, 4'b1100};

        rst_n = 1'b0; en = 1'b1; digits_in = 16'h1234; dp_in = 4'b1111; blank_lz = 1'b0;

        // Reset state and first-slot latency after release
        step(3);
        chk("rst_bcd", bcd_out, 4'hF);
        chk("rst_sel", digit_sel, 4'b1111);
        chk("rst_dp", dp_out, 1'b0);
        chk("rst_fs", frame_start, 1'b0);
        @(negedge clk); rst_n = 1'b1;
        step(3);
        chk("pre_tick_sel", digit_sel, 4'b1111);
        step(1);
        chk("first_sel", digit_sel, 4'b0111);
        chk("first_bcd", bcd_out, 4'h1);
        chk("first_fs", frame_start, 1'b1);
        chk("first_dp", dp_out, 1'b1);

        // Asynchronous reset mid-cycle takes effect without a clock edge
        step(5);
        #2 rst_n = 1'b0;
        #1;
        chk("async_bcd", bcd_out, 4'hF);
        chk("async_sel", digit_sel, 4'b1111);
        chk("async_dp", dp_out, 1'b0);
        @(negedge clk); rst_n = 1'b1;
        step(4);
        chk("rerst_sel", digit_sel, 4'b0111);
        chk("rerst_fs", frame_start, 1'b1);

        // Frame-level vectors
        for (int v = 0; v < 8; v++) begin
            digits_in = vecs[v].digits;
            dp_in     = vecs[v].dp;
            blank_lz  = vecs[v].blz;
            wait_frame($sformatf("v%0d", v));
            for (int s = 0; s < 4; s++) begin
                logic [15:0] eb;
                logic [3:0]  ed;
                logic [3:0]  es;
                eb = vecs[v].exp_bcd;
                ed = vecs[v].exp_dp;
                es = ~(4'b1000 >> s);
                chk($sformatf("v%0d_s%0d_bcd", v, s), bcd_out, eb[15-4*s -: 4]);
                chk($sformatf("v%0d_s%0d_sel", v, s), digit_sel, es);
                chk($sformatf("v%0d_s%0d_dp", v, s), dp_out, ed[3-s]);
                chk($sformatf("v%0d_s%0d_fs", v, s), frame_start, s == 0);
                step(3);
                chk($sformatf("v%0d_s%0d_hold", v, s), {frame_start, digit_sel, bcd_out}, {1'b0, es, eb[15-4*s -: 4]});
                if (s < 3) step(1);
            end
        end

        // Snapshot: mid-frame change is invisible until the next frame
        digits_in = 16'h1234; dp_in = 4'b0000; blank_lz = 1'b0;
        wait_frame("snap");
        chk("snap_s0", bcd_out, 4'h1);
        step(4);
        chk("snap_s1", bcd_out, 4'h2);
        digits_in = 16'h5678;
        step(4);
        chk("snap_s2", bcd_out, 4'h3);
        step(4);
        chk("snap_s3", bcd_out, 4'h4);
        step(4);
        chk("snap_n0", bcd_out, 4'h5);
        chk("snap_n0_fs", frame_start, 1'b1);
        step(4);
        chk("snap_n1", bcd_out, 4'h6);
        chk("snap_n1_sel", digit_sel, 4'b1011);

        // Enable drop during slot 2, then restart at the MS digit
        en = 1'b0;
        step(1);
        chk("en_off_sel", digit_sel, 4'b1111);
        chk("en_off_bcd", bcd_out, 4'hF);
        chk("en_off_dp", dp_out, 1'b0);
        step(5);
        chk("en_frozen", {frame_start, digit_sel}, {1'b0, 4'b1111});
        en = 1'b1;
        step(3);
        chk("en_pre_sel", digit_sel, 4'b1111);
        step(1);
        chk("en_on_sel", digit_sel, 4'b0111);
        chk("en_on_fs", frame_start, 1'b1);
        chk("en_on_bcd", bcd_out, 4'h5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
